// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: slices store data into byte lanes for a synchronous RAM
// and extracts/extends load results, with a valid/ready handshake toward the pipeline.
module mem_lsu #(
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [1:0]        req_size,
   input  logic              req_unsigned,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              mem_en,
   output logic [3:0]        mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata,
   output logic              rsp_valid,
   output logic [31:0]       rsp_rdata,
   output logic              rsp_err
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

   state_t      state, state_next;
   logic        cap_we, cap_unsigned;
   logic [1:0]  cap_size, cap_off;
   logic        accept, req_err;
   logic [3:0]  lane_we;
   logic [31:0] lane_wdata, load_data;
   logic [7:0]  rd_byte;
   logic [15:0] rd_half;

   assign req_ready = (state == IDLE);
   assign accept    = req_valid & req_ready;

   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      req_err    = 1'b0;
      lane_we    = 4'b1111;
      lane_wdata = req_wdata;
      case (req_size)
         2'b00: begin
            lane_we    = 4'b0001 << req_addr[1:0];
            lane_wdata = {4{req_wdata[7:0]}};
         end
         2'b01: begin
            req_err    = req_addr[0];
            lane_we    = req_addr[1] ? 4'b1100 : 4'b0011;
            lane_wdata = {2{req_wdata[15:0]}};
         end
         2'b10:   req_err = |req_addr[1:0];
         default: req_err = 1'b1;
      endcase
   end

   // Extension fill bit is the extracted MSB unless the load is unsigned.
   always_comb begin
      rd_byte = mem_rdata[{cap_off, 3'b000} +: 8];
      rd_half = mem_rdata[{cap_off[1], 4'b0000} +: 16];
      case (cap_size)
         2'b00:   load_data = {{24{rd_byte[7] & ~cap_unsigned}}, rd_byte};
         2'b01:   load_data = {{16{rd_half[15] & ~cap_unsigned}}, rd_half};
         default: load_data = mem_rdata;
      endcase
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (accept) state_next = req_err ? DONE : ISSUE;
         ISSUE:   state_next = cap_we ? DONE : WAIT;
         WAIT:    state_next = DONE;
         default: state_next = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cap_we       <= 1'b0;
         cap_unsigned <= 1'b0;
         cap_size     <= 2'b00;
         cap_off      <= 2'b00;
         mem_en       <= 1'b0;
         mem_we       <= 4'b0000;
         mem_addr     <= '0;
         mem_wdata    <= '0;
         rsp_valid    <= 1'b0;
         rsp_rdata    <= '0;
         rsp_err      <= 1'b0;
      end else begin
         mem_en    <= 1'b0;
         mem_we    <= 4'b0000;
         rsp_valid <= (state_next == DONE);
         if (accept) begin
            cap_we       <= req_we;
            cap_unsigned <= req_unsigned;
            cap_size     <= req_size;
            cap_off      <= req_addr[1:0];
            mem_addr     <= {req_addr[ADDR_W-1:2], 2'b00};
            mem_wdata    <= lane_wdata;
            if (req_err) begin
               rsp_err   <= 1'b1;
               rsp_rdata <= '0;
            end else begin
               mem_en <= 1'b1;
               mem_we <= req_we ? lane_we : 4'b0000;
            end
         end
         if (state == ISSUE && cap_we) begin
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
         end
         if (state == WAIT) begin
            rsp_err   <= 1'b0;
            rsp_rdata <= load_data;
         end
      end
   end

endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu with a synchronous byte-writable RAM model.
module tb_mem_lsu;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid, req_ready, req_we, req_unsigned;
   logic [1:0]  req_size;
   logic [31:0] req_addr, req_wdata;
   logic        mem_en;
   logic [3:0]  mem_we;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic        rsp_valid, rsp_err;
   logic [31:0] rsp_rdata;

   int checks = 0;
   int failures = 0;

   logic [31:0] ram [0:255];

   mem_lsu #(.ADDR_W(32)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
      .req_wdata(req_wdata), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .rsp_valid(rsp_valid),
      .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (mem_en) begin
         for (int b = 0; b < 4; b++)
            if (mem_we[b]) ram[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
         if (mem_we == 4'b0000) mem_rdata <= ram[mem_addr[9:2]];
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Issues one request and follows it to its response (bounded to 8 cycles).
   task automatic access(input string tag, input logic we, input logic [1:0] size,
                         input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                         output int lat, output logic saw_en, output logic [3:0] we_s,
                         output logic [31:0] addr_s, output logic [31:0] wdata_s,
                         output logic [31:0] rdata, output logic err);
      @(negedge clk);
      req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
      req_addr = addr; req_wdata = wdata;
      check({tag, " ready"}, {31'd0, req_ready}, 32'd1);
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      lat = 0; saw_en = 1'b0; we_s = '0; addr_s = '0; wdata_s = '0; rdata = '0; err = 1'b0;
      for (int i = 1; i <= 8; i++) begin
         if (mem_en && !saw_en) begin
            saw_en = 1'b1; we_s = mem_we; addr_s = mem_addr; wdata_s = mem_wdata;
         end
         if (rsp_valid) begin
            lat = i; rdata = rsp_rdata; err = rsp_err;
            break;
         end
         @(negedge clk);
      end
      @(negedge clk);
      check({tag, " pulse end"}, {31'd0, rsp_valid}, 32'd0);
   endtask

   int          lat, pulses;
   logic        saw_en, err, second;
   logic [3:0]  we_s;
   logic [31:0] addr_s, wdata_s, rdata, b2b_rdata;

   initial begin
      for (int i = 0; i < 256; i++) ram[i] = 32'h0;
      ram[8'h40] = 32'h12F0_3456;
      ram[8'h80] = 32'h8001_7FFF;
      mem_rdata = '0;
      req_valid = 0; req_we = 0; req_size = 0; req_unsigned = 0; req_addr = 0; req_wdata = 0;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      check("reset ready", {31'd0, req_ready}, 32'd1);
      check("reset outputs", {mem_en, rsp_valid, rsp_err, 1'b0, mem_we, 24'd0}, 32'd0);
      rst_n = 1'b1;

      access("lb s", 1'b0, 2'b00, 1'b0, 32'h102, 32'h0, lat, saw_en, we_s, addr_s, wdata_s, rdata, err);
      check("lb s data", rdata, 32'hFFFF_FFF0);
      check("lb s lat", lat, 3);
      check("lb s mem_addr", addr_s, 32'h100);
      check("lb s mem_we", {28'd0, we_s}, 32'd0);
      access("lbu", 1'b0, 2'b00, 1'b1, 32'h102, 32'h0, lat, saw_en, we_s, addr_s, wdata_s, rdata, err);
      check("lbu data", rdata, 32'h0000_00F0);
      check("lbu err", {31'd0, err}, 32'd0);
      access("lh hi", 1'b0, 2'b01, 1'b0, 32'h202, 32'h0, lat, saw_en, we_s, addr_s, wdata_s, rdata, err);
      check("lh hi data", rdata, 32'hFFFF_8001);
      access("lh lo", 1'b0, 2'b01, 1'b0, 32'h200, 32'h0, lat, saw_en, we_s, addr_s, wdata_s, rdata, err);
      check("lh lo data", rdata, 32'h0000_7FFF);
      access("lhu hi", 1'b0, 2'b01, 1'b1, 32'h202, 32'h0, lat, saw_en, we_s, addr_s, wdata_s, rdata, err);
      check("lhu hi data", rdata, 32'h0000_8001);

      access("sb", 1'b1, 2'b00, 1'b0, 32'h103, 32'h1234_56A5, lat, saw_en, we_s, addr_s, wdata_s, rdata, err);
      check("sb mem_we", {28'd0, we_s}, 32'h8);
      check("sb mem_wdata", wdata_s, 32'hA5A5_A5A5);
      check("sb mem_addr", addr_s, 32'h100);
      check("sb lat", lat, 2);
      check("sb err", {31'd0, err}, 32'd0);
      access("lw after sb", 1'b0, 2'b10, 1'b0, 32'h100, 32'h0, lat, saw_en, we_s, addr_s, wdata_s, rdata, err);
      check("lw after sb data", rdata, 32'hA5F0_3456);
      access("sh", 1'b1, 2'b01, 1'b0, 32'h202, 32'hFFFF_BEEF, lat, saw_en, we_s, addr_s, wdata_s, rdata, err);
      check("sh mem_we", {28'd0, we_s}, 32'hC);
      check("sh mem_wdata", wdata_s, 32'hBEEF_BEEF);

      access("err lw", 1'b0, 2'b10, 1'b0, 32'h105, 32'h0, lat, saw_en, we_s, addr_s, wdata_s, rdata, err);
      check("err lw flags", {30'd0, saw_en, err}, 32'd1);
      check("err lw lat", lat, 1);
      check("err lw data", rdata, 32'd0);
      access("err sh", 1'b1, 2'b01, 1'b0, 32'h101, 32'h55, lat, saw_en, we_s, addr_s, wdata_s, rdata, err);
      check("err sh flags", {30'd0, saw_en, err}, 32'd1);
      check("err sh lat", lat, 1);
      access("err size", 1'b0, 2'b11, 1'b0, 32'h100, 32'h0, lat, saw_en, we_s, addr_s, wdata_s, rdata, err);
      check("err size flags", {30'd0, saw_en, err}, 32'd1);
      check("err size data", rdata, 32'd0);

      // Reset while the load sits in WAIT.
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_addr = 32'h100;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("rst mid ready", {31'd0, req_ready}, 32'd1);
      check("rst mid addr", mem_addr, 32'd0);
      check("rst mid outs", {mem_en, rsp_valid, rsp_err, 1'b0, mem_we, 24'd0} | rsp_rdata | mem_wdata, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      pulses = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (rsp_valid) pulses++;
      end
      check("rst mid no rsp", pulses, 0);

      // Back-to-back: request held high, store word then load word.
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_unsigned = 1'b0;
      req_addr = 32'h40; req_wdata = 32'hDEAD_BEEF;
      @(posedge clk);
      pulses = 0; second = 1'b0; b2b_rdata = '0;
      for (int i = 1; i <= 10; i++) begin
         @(negedge clk);
         if (i == 1) begin
            check("b2b ready low k+1", {31'd0, req_ready}, 32'd0);
            req_we = 1'b0;
         end
         if (i == 2) check("b2b ready low done", {31'd0, req_ready}, 32'd0);
         if (rsp_valid) begin
            pulses++;
            b2b_rdata = rsp_rdata;
         end
         if (second) req_valid = 1'b0;
         if (req_ready && i > 1) second = 1'b1;
      end
      req_valid = 1'b0;
      check("b2b pulses", pulses, 2);
      check("b2b load data", b2b_rdata, 32'hDEAD_BEEF);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
